uart_rx_ovs: RTL
================

// Module: uart_rx_ovs
// PURPOSE
//  Parametrised oversampling UART receiver: 2-flop input synchroniser, runtime baud divisor,
//  3-sample majority vote per bit, configurable parity/stop bits, break detection.
//  Delivers frames on a valid/ready output register with parity/framing/overrun flags.
//  Sits between the board RX pin and the link-layer/host FIFO; successor to the fixed 8N1 receiver.
// PARAMETERS
//  DATA_WIDTH   8            data bits per frame, legal 5..9, LSB first on the line
//  CLK_FREQ     50_000_000   clk frequency in Hz
//  BAUD_RATE    115_200      default line rate; only used to derive DIV_DEFAULT
//  OVERSAMPLE   16           sample ticks per bit, even, >= 8
//  DIV_W        16           width of cfg_div
//  DIV_DEFAULT  CLK_FREQ/(BAUD_RATE*OVERSAMPLE) (=27)   value a bench drives on cfg_div by default
// PORTS
//  clk            in   1           system clock
//  reset          in   1           asynchronous, active-high reset
//  ena            in   1           receiver enable; low = hold in IDLE
//  rx             in   1           asynchronous serial line, idle high
//  cfg_div        in   DIV_W       clk cycles per sample tick; 0 treated as 1
//  cfg_parity     in   2           parity_e: 00 none, 01 even, 10 odd, 11 = none
//  cfg_stop2      in   1           1 = two stop bits expected
//  rx_data        out  DATA_WIDTH  received data word
//  rx_valid       out  1           rx_data + flags valid
//  rx_ready       in   1           consumer accepts when rx_valid && rx_ready
//  rx_parity_err  out  1           parity mismatch for the held word
//  rx_frame_err   out  1           a stop bit sampled low for the held word
//  overrun        out  1           1-cycle pulse: frame completed while holding register full, frame dropped
//  break_det      out  1           1-cycle pulse on break entry
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; tick/bit counters 0; sync flops and the majority-vote
//    sample shift register set to 1 (line idle).
//  - Tick gen: down-counter reloads max(cfg_div,1)-1 and emits 1-cycle tick at 0. Counter is
//    cleared while in IDLE, so tick phase is aligned to the detected start edge.
//  - Sample index s counts 0..OVERSAMPLE-1 per bit on ticks. Bit value = majority of samples at
//    s = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1; decision taken at OVERSAMPLE/2+1.
//  - cfg_div/cfg_parity/cfg_stop2 latched at start detection; changes mid-frame have no effect.
//  - FSM:
//    IDLE   -> START on synchronised rx == 0 with ena == 1.
//    START  -> at decision: voted 1 = false start -> IDLE (no output); voted 0 -> DATA at s wrap.
//    DATA   -> DATA_WIDTH bits shifted LSB-first; -> PARITY if parity enabled, else STOP.
//    PARITY -> STOP; err = voted bit != (^data ^ odd).
//    STOP   -> first stop: a voted 0 sets frame_err. If cfg_stop2, wait s wrap and vote the
//              second stop the same way. At decision of final stop: if data == 0, parity bit
//              (when present) == 0 and final stop == 0 -> BREAK; else complete -> IDLE immediately
//              (no wait for bit end, allows back-to-back frames at up to +/-3% rate error).
//    BREAK  -> break_det pulse on entry; no rx_valid; stay until synchronised rx == 1 -> IDLE.
//  - Completion: the cycle after the final-stop decision tick, rx_data/flags load and rx_valid = 1.
//    Completion when rx_valid=1 and rx_ready=0: overrun pulses, the held word and flags are
//    unchanged, and the new frame is lost. Completion in the same cycle as an accepting
//    handshake: the new word loads, rx_valid stays 1, no overrun.
//  - rx_valid clears the cycle after rx_valid && rx_ready if no completion is pending.
//    Error flags are sticky with the word they describe.
//  - ena low: FSM -> IDLE next cycle and any partial frame is discarded. Output register and
//    handshake keep working.
//  - Reset asserted mid-frame: everything returns to reset values asynchronously.
// STRUCTURE
//  - uart_pkg: parity_e enum, rx_state_e {IDLE,START,DATA,PARITY,STOP,BREAK}, majority3() function.
//  - Sub-module uart_baud_tick (divisor down-counter, sync clear, tick out); the rest stays inline.
// TESTING  (cfg_div=27, OVERSAMPLE=16, rx_ready=1 unless stated)
//  1. 8N1 frame 0xA5 -> rx_data=0xA5, rx_valid 1 cycle, parity_err=frame_err=0.
//  2. Even parity, 0x07 sent with parity bit 0 -> rx_data=0x07, rx_parity_err=1; 0x07 with
//     parity 1 -> err=0.
//  3. 0x3C with stop bit driven low (data nonzero) -> rx_frame_err=1, no break_det;
//     cfg_stop2=1 with 2nd stop low -> frame_err=1.
//  4. rx low for 4 ticks only -> no rx_valid, FSM back in IDLE; 0x5A with a 1-tick glitch at a
//     bit's mid-sample -> 0x5A received clean.
//  5. rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once; raise
//     rx_ready -> rx_valid drops next cycle.
//  6. rx low for 3 frame times -> one break_det pulse, no rx_valid, then 0x55 received;
//     reset/ena low mid-frame -> outputs 0, next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Parity encoding, receiver state encoding and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: divisor down-counter with synchronous clear.
// A clear leaves the counter at 0 so the first tick follows immediately.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] load;

    assign load = (div == '0) ? '0 : div - 1'b1;
    assign tick = !clear && (cnt == '0);

    // Count down to zero, then reload from the divisor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= load;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority vote, parity, stop bits,
// break detection and a valid/ready output holding register.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  rx,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  overrun,
    output logic                  break_det
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] NBITS  = BW'(DATA_WIDTH);

    logic                  sync1, sync2, rx_s;
    rx_state_e             state;
    logic [SW-1:0]         s;
    logic [1:0]            samp;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic [DIV_W-1:0]      div_q;
    parity_e               par_q;
    logic                  stop2_q;
    logic                  par_bit, ferr_acc, second_stop;
    logic                  tick, vote, decide, wrap;
    logic                  par_en, par_err, final_stop, is_break, complete;

    assign rx_s       = sync2;
    assign vote       = majority3(samp[1], samp[0], rx_s);
    assign decide     = tick && (s == S_DEC);
    assign wrap       = tick && (s == S_LAST);
    assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign par_err    = par_en && (par_bit != (^shreg ^ (par_q == PAR_ODD)));
    assign final_stop = (state == STOP) && (!stop2_q || second_stop);
    assign is_break   = (shreg == '0) && (!par_en || !par_bit) && !vote;
    assign complete   = ena && decide && final_stop && !is_break;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .div   (div_q),
        .tick  (tick)
    );

    // Two-flop synchroniser on the line, idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end

    // Frame FSM: sample index, vote history, data shift and break entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            s           <= '0;
            samp        <= 2'b11;
            shreg       <= '0;
            bit_cnt     <= '0;
            div_q       <= DIV_W'(DIV_DEFAULT);
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            par_bit     <= 1'b0;
            ferr_acc    <= 1'b0;
            second_stop <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            break_det <= 1'b0;
            if (tick) begin
                samp <= {samp[0], rx_s};
                s    <= wrap ? '0 : s + 1'b1;
            end
            if (!ena) begin
                state <= IDLE;
                s     <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        s <= '0;
                        if (!rx_s) begin
                            state       <= START;
                            div_q       <= cfg_div;
                            par_q       <= parity_e'(cfg_parity);
                            stop2_q     <= cfg_stop2;
                            bit_cnt     <= '0;
                            par_bit     <= 1'b0;
                            ferr_acc    <= 1'b0;
                            second_stop <= 1'b0;
                        end
                    end
                    START: begin
                        if (decide && vote) begin
                            state <= IDLE;
                        end else if (wrap) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (decide) begin
                            shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (wrap && bit_cnt == NBITS) begin
                            bit_cnt <= '0;
                            state   <= par_en ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        if (decide) begin
                            par_bit <= vote;
                        end
                        if (wrap) begin
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (decide) begin
                            if (!vote) begin
                                ferr_acc <= 1'b1;
                            end
                            if (final_stop) begin
                                if (is_break) begin
                                    state     <= BREAK;
                                    break_det <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                second_stop <= 1'b1;
                            end
                        end
                    end
                    BREAK: begin
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Output holding register with overrun detection and handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data       <= shreg;
                    rx_valid      <= 1'b1;
                    rx_parity_err <= par_err;
                    rx_frame_err  <= ferr_acc | !vote;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
